// File: rtl/baud_tick_gen.sv
// Two-level baud tick generator: divide-by-div s_tick, divide-by-os bit_tick; ticks are combinational on the current count.
// Config accepted when cfg_ready is high, held pending (cfg_ready low) until the next bit boundary, en=0 or clr.
module baud_tick_gen #(
  parameter int DIV_W       = 16,
  parameter int OS_W        = 5,
  parameter int DEFAULT_DIV = 326,
  parameter int DEFAULT_OS  = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             clr,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [OS_W-1:0]  cfg_os,
  output logic             cfg_err,
  output logic             s_tick,
  output logic             bit_tick,
  output logic [DIV_W-1:0] q,
  output logic [OS_W-1:0]  os_q
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_cur;
  logic [DIV_W-1:0] pend_div;
  logic [DIV_W-1:0] div_last;
  logic [OS_W-1:0]  sub;
  logic [OS_W-1:0]  os_cur;
  logic [OS_W-1:0]  pend_os;
  logic [OS_W-1:0]  os_last;
  logic             pending;
  logic             s_wrap;
  logic             sub_wrap;
  logic             cfg_acc;
  logic             cfg_bad;
  logic             cfg_apply;

  // Illegal divisors are never latched, so these subtractions cannot underflow.
  assign div_last  = div_cur - DIV_W'(1);
  assign os_last   = os_cur - OS_W'(1);

  assign s_wrap    = (cnt == div_last);
  assign sub_wrap  = (sub == os_last);
  assign s_tick    = en & ~clr & s_wrap;
  assign bit_tick  = s_tick & sub_wrap;

  assign cfg_ready = ~pending;
  assign cfg_acc   = cfg_valid & ~pending;
  assign cfg_bad   = (cfg_div < DIV_W'(2)) | (cfg_os == '0);
  assign cfg_apply = pending & (bit_tick | ~en | clr);

  assign q         = cnt;
  assign os_q      = sub;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      sub <= '0;
    end else if (clr) begin
      cnt <= '0;
      sub <= '0;
    end else if (en) begin
      cnt <= s_wrap ? '0 : cnt + DIV_W'(1);
      if (s_tick) begin
        sub <= sub_wrap ? '0 : sub + OS_W'(1);
      end
    end
  end

  // Accept and apply are mutually exclusive: accept needs pending low, apply needs it high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cur  <= DIV_W'(DEFAULT_DIV);
      os_cur   <= OS_W'(DEFAULT_OS);
      pend_div <= DIV_W'(DEFAULT_DIV);
      pend_os  <= OS_W'(DEFAULT_OS);
      pending  <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      cfg_err <= cfg_acc & cfg_bad;
      if (cfg_apply) begin
        div_cur <= pend_div;
        os_cur  <= pend_os;
        pending <= 1'b0;
      end else if (cfg_acc && !cfg_bad) begin
        pend_div <= cfg_div;
        pend_os  <= cfg_os;
        pending  <= 1'b1;
      end
    end
  end

endmodule

// File: doc/baud_tick_gen.md
# baud_tick_gen

Programmable two-level baud-rate tick generator for the UART path. A divide-by-`div` stage produces the oversampling tick `s_tick` for the UART RX/TX samplers. A divide-by-`os` stage counts `s_tick`s and produces the per-bit tick `bit_tick`. Both divisors change at runtime through a valid/ready configuration port, and new values take effect only on a bit boundary, so a frame in flight never sees a torn bit period.

## Interface
- `DIV_W`, 16: width of the divisor and the main counter.
- `OS_W`, 5: width of the oversample ratio and the sub-counter.
- `DEFAULT_DIV`, 326: divisor after reset (100 MHz / (19200 × 16)).
- `DEFAULT_OS`, 16: oversample ratio after reset.

Ports:
- `clk`  in  1  the single clock; all logic on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable.
- `clr`  in  1  synchronous clear of both counters.
- `cfg_valid`  in  1  configuration request.
- `cfg_ready`  out  1  high when no update is pending.
- `cfg_div`  in  DIV_W  requested divisor; legal range 2..2^DIV_W−1.
- `cfg_os`  in  OS_W  requested oversample ratio; legal range 1..2^OS_W−1.
- `cfg_err`  out  1  one-cycle pulse when an illegal request is accepted.
- `s_tick`  out  1  oversampling tick.
- `bit_tick`  out  1  bit tick; always coincides with an `s_tick`.
- `q`  out  DIV_W  main counter value.
- `os_q`  out  OS_W  sub-counter value.

## Operation
- State registers: `cnt`, `sub`, `div_cur`, `os_cur`, `pend_div`, `pend_os`, `pending`, `cfg_err`.
- Reset (`reset_n`=0) values:
  - `cnt`=0, `sub`=0.
  - `div_cur`=`DEFAULT_DIV`, `os_cur`=`DEFAULT_OS`.
  - `pending`=0, `cfg_err`=0.
  - Resulting outputs: `cfg_ready`=1, `s_tick`=0, `bit_tick`=0, `q`=0, `os_q`=0.
- Combinational outputs:
  - `s_tick` = `en` & !`clr` & (`cnt`==`div_cur`−1).
  - `bit_tick` = `s_tick` & (`sub`==`os_cur`−1).
  - `cfg_ready` = !`pending`.
  - `q`=`cnt`, `os_q`=`sub`.
- Counter update, highest priority first:
  - `clr`=1: `cnt`←0, `sub`←0.
  - else `en`=0: hold both counters.
  - else main stage: `cnt`←(`cnt`==`div_cur`−1) ? 0 : `cnt`+1.
  - else sub stage, only when `s_tick`=1: `sub`←(`sub`==`os_cur`−1) ? 0 : `sub`+1.
- Config accept happens when `cfg_valid` & `cfg_ready`:
  - If `cfg_div`<2 or `cfg_os`==0: `cfg_err`←1 for exactly one cycle, and nothing is latched.
  - Otherwise: `pend_div`←`cfg_div`, `pend_os`←`cfg_os`, `pending`←1.
  - `cfg_err` is otherwise 0 every cycle.
- Config apply happens when `pending`=1 and any of `bit_tick`=1, `en`=0, or `clr`=1 holds:
  - `div_cur`←`pend_div`, `os_cur`←`pend_os`, `pending`←0.
  - When the apply is triggered by `bit_tick`, the counters wrap to 0 in that same cycle.
- Divisor regions:
  - `os_cur`=1 makes `bit_tick` identical to `s_tick`.
  - `div_cur`=2 gives an `s_tick` every second enabled cycle.
- Width rules:
  - All compares are on `DIV_W`/`OS_W`-bit unsigned values.
  - `div_cur`−1 and `os_cur`−1 never underflow, because illegal values are never latched.

## Timing
- `s_tick` period is `div_cur` enabled cycles.
  - The first `s_tick` after reset or `clr` occurs on the `div_cur`-th enabled cycle.
- `bit_tick` period is `div_cur`×`os_cur` enabled cycles.
- Config latency:
  - Accept cycle N gives `cfg_ready`=0 at N+1.
  - The new values are used from the cycle after the apply cycle.
  - `cfg_ready` returns to 1 in that same cycle.
- `cfg_err` asserts in cycle N+1 after the accept cycle N.
- `cfg_valid` while `cfg_ready`=0 is ignored: no accept and no error.
- Holding `en`=0 freezes the counters; ticks resume counting from the frozen values.
- `clr` together with `en`=1 in the same cycle: no tick, and both counters go to 0.
- Accept in the same cycle as a `bit_tick`: the value is only stored as pending and applies at the next boundary.
- Mid-operation `reset_n` assertion returns everything to reset values immediately.
  - Any pending configuration is discarded.

## Test plan
- Reset with `en`=1, `DEFAULT_DIV`=4, `DEFAULT_OS`=2 → `s_tick` on cycles 4, 8, 12; `bit_tick` on cycles 8, 16.
- Running with div=4/os=2, accept `cfg_div`=3, `cfg_os`=3 at cycle 10:
  - `cfg_ready`=0 during cycles 11–16.
  - Apply at the `bit_tick` in cycle 16.
  - Next `s_tick`s at cycles 19, 22, 25; next `bit_tick` at cycle 25.
- `cfg_div`=1 and, separately, `cfg_os`=0 → `cfg_err` pulses for one cycle; `div_cur`/`os_cur` unchanged; `cfg_ready` stays 1.
- `en` held low for 5 cycles when `cnt`=2 → `q` stays 2 and no ticks; the next `s_tick` comes 1 enabled cycle after release.
- Assert `clr` when `cnt`=3 with an update pending → no tick in that cycle; `q`=0 and `os_q`=0; the new divisor is active from the next cycle.
- Drive `reset_n` low asynchronously with an update pending and `cnt`≠0 → outputs reach their reset values before the next clock edge; the pending update is lost.
